// File: rtl/periph_tx_handshake.sv
// periph_tx_handshake: DEPTH-entry FIFO feeding a 4-phase (return-to-zero)
// send/ack transmitter. ack is asynchronous and is brought in through a
// 2-flop synchronizer. Optional build macro TX_ACK_TIMEOUT_EN adds a per-phase
// timeout that sets the sticky err flag; without it err is tied low.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no word offered; waits for data and ack_s low
// SEND     | send=1, dado holds the head word; waits for ack_s high
// WAIT_LOW | send=0; waits for ack_s to return low before the next word
module periph_tx_handshake #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk1,
    input  logic                   rst1,
    input  logic                   wr_en,
    input  logic [1:0]             wr_data,
    input  logic                   ack,
    output logic                   send,
    output logic [1:0]             dado,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("periph_tx_handshake: illegal DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ack_m;
    logic            r_ack_s;
    logic [1:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_send;
    logic [1:0]      r_dado;
    logic            w_push;
    logic            w_pop;
    logic            w_launch;
    logic            w_tmo;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign send   = r_send;
    assign dado   = r_dado;
    // A push is refused while full, even if the head pops on the same edge.
    assign w_push = wr_en && !full;

    // Two-flop synchronizer for the asynchronous ack.
    always_ff @(posedge clk1) begin
        if (!rst1) begin
            r_ack_m <= 1'b0;
            r_ack_s <= 1'b0;
        end else begin
            r_ack_m <= ack;
            r_ack_s <= r_ack_m;
        end
    end

    // FIFO storage; contents need no reset because the pointers/count define validity.
    always_ff @(posedge clk1) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk1) begin
        if (!rst1) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef TX_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic          w_err_set;

    // Per-phase down-counter, reloaded on every state change; terminal count is zero.
    always_ff @(posedge clk1) begin
        if (!rst1) begin
            r_tmo <= TW'(TIMEOUT_CYCLES - 1);
        end else if (w_state_nxt != r_state) begin
            r_tmo <= TW'(TIMEOUT_CYCLES - 1);
        end else if (r_state != ST_IDLE && r_tmo != '0) begin
            r_tmo <= r_tmo - 1'b1;
        end
    end

    assign w_tmo     = (r_state != ST_IDLE) && (r_tmo == '0);
    // Only a timeout that actually forces the exit counts as an error.
    assign w_err_set = w_tmo && ((r_state == ST_SEND && !r_ack_s) ||
                                 (r_state == ST_WAIT_LOW && r_ack_s));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk1) begin
        if (!rst1) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    // Next-state decode; an ack level other than the awaited one is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!empty && !r_ack_s) begin
                    w_state_nxt = ST_SEND;
                    w_launch    = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_ack_s) begin
                    w_state_nxt = ST_WAIT_LOW;
                    w_pop       = 1'b1;
                end else if (w_tmo) begin
                    w_state_nxt = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!r_ack_s || w_tmo) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered send/dado; dado only changes on a launch.
    always_ff @(posedge clk1) begin
        if (!rst1) begin
            r_state <= ST_IDLE;
            r_send  <= 1'b0;
            r_dado  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= (w_state_nxt == ST_SEND);
            if (w_launch) begin
                r_dado <= r_mem[r_rptr];
            end
        end
    end
endmodule

// File: tb/tb_periph_tx_handshake.sv
// Bench for periph_tx_handshake: directed stimulus, expected words queued at
// push time, monitor pops and compares on every send rise. Ack comes from a
// responder process (auto / held low / forced high).
module tb_periph_tx_handshake;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int M_AUTO = 0, M_LOW = 1, M_HIGH = 2;

    logic       clk1 = 1'b0;
    logic       rst1;
    logic       wr_en;
    logic [1:0] wr_data;
    logic       ack;
    logic       send;
    logic [1:0] dado;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];
    int         ack_mode = M_LOW;
    int         ack_dly  = 3;

    periph_tx_handshake #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk1(clk1), .rst1(rst1), .wr_en(wr_en), .wr_data(wr_data), .ack(ack),
        .send(send), .dado(dado), .full(full), .empty(empty), .count(count), .err(err)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic push(input logic [1:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) exp_q.push_back(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_send(input logic lvl, input int bound, input string nm);
        int n;
        n = 0;
        while (send !== lvl && n < bound) begin
            tick();
            n++;
        end
        check(nm, int'(send === lvl), 1);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (!(count == 0 && !send && !ack) && n < 300) begin
            tick();
            n++;
        end
        check(nm, int'(count == 0 && !send), 1);
        repeat (3) tick();
    endtask

    // Ack responder, driven on the falling edge so its timing is deterministic.
    initial begin
        int dcnt;
        ack  = 1'b0;
        dcnt = 0;
        forever begin
            @(negedge clk1);
            if (ack_mode == M_HIGH) begin
                ack = 1'b1;
            end else if (ack_mode == M_LOW) begin
                ack  = 1'b0;
                dcnt = 0;
            end else if (!send) begin
                ack  = 1'b0;
                dcnt = 0;
            end else if (!ack) begin
                dcnt++;
                if (dcnt >= ack_dly) ack = 1'b1;
            end
        end
    end

    // Monitor: every send rise must carry the oldest expected word, held while send is high.
    initial begin
        logic       prev_send;
        logic [1:0] cur;
        prev_send = 1'b0;
        cur       = 2'b00;
        forever begin
            tick();
            if (send && !prev_send) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_send: dado=%0d with no word expected at %0t", dado, $time);
                end else begin
                    cur = exp_q.pop_front();
                    check("delivered_word", dado, cur);
                end
            end else if (send) begin
                check("dado_stable", dado, cur);
            end
            prev_send = send;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst1    = 1'b0;
        wr_en   = 1'b0;
        wr_data = 2'b00;
        repeat (3) tick();
        check("rst_send", send, 0);
        check("rst_dado", dado, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        rst1 = 1'b1;
        repeat (2) tick();

        // Single word with a 3-cycle responder.
        ack_mode = M_AUTO;
        ack_dly  = 3;
        push(2'b10, 1'b1);
        check("sw_count_after_push", count, 1);
        check("sw_send_after_push", send, 0);
        tick();
        check("sw_send_rise", send, 1);
        check("sw_dado", dado, 2'b10);
        wait_send(1'b0, 30, "sw_send_fall");
        check("sw_count_after_pop", count, 0);
        check("sw_empty_after_pop", empty, 1);
        repeat (4) tick();

        // Burst of five with no ack: fifth is rejected.
        ack_mode = M_LOW;
        push(2'b00, 1'b1); check("burst_count1", count, 1);
        push(2'b01, 1'b1); check("burst_count2", count, 2);
        push(2'b10, 1'b1); check("burst_count3", count, 3);
        check("burst_full3", full, 0);
        push(2'b11, 1'b1); check("burst_count4", count, 4);
        check("burst_full4", full, 1);
        push(2'b01, 1'b0); check("burst_rejected_count", count, 4);
        check("burst_full5", full, 1);
        ack_mode = M_AUTO;
        ack_dly  = 1;
        wait_drain("burst_drain");
        check("burst_empty", empty, 1);

        // Push while full, pop on the same edge.
        ack_mode = M_LOW;
        push(2'b11, 1'b1);
        push(2'b10, 1'b1);
        push(2'b01, 1'b1);
        push(2'b00, 1'b1);
        check("pf_full", full, 1);
        check("pf_send", send, 1);
        ack_mode = M_HIGH;
        wr_en    = 1'b1;
        wr_data  = 2'b01;
        tick(); check("pf_count_e1", count, 4);
        tick(); check("pf_count_e2", count, 4);
        tick(); check("pf_count_pop", count, 3);
        check("pf_full_after", full, 0);
        check("pf_send_after", send, 0);
        wr_en    = 1'b0;
        ack_mode = M_AUTO;
        ack_dly  = 2;
        wait_drain("pf_drain");

        // Reset mid-handshake discards everything.
        ack_mode = M_LOW;
        push(2'b11, 1'b1);
        push(2'b00, 1'b1);
        push(2'b10, 1'b1);
        check("rm_pre_send", send, 1);
        check("rm_pre_count", count, 3);
        rst1 = 1'b0;
        exp_q.delete();
        tick();
        check("rm_send", send, 0);
        check("rm_count", count, 0);
        check("rm_empty", empty, 1);
        rst1 = 1'b1;
        repeat (10) tick();
        check("rm_no_send", send, 0);
        ack_mode = M_AUTO;
        ack_dly  = 2;
        push(2'b01, 1'b1);
        wait_send(1'b1, 10, "rm_new_send");
        wait_drain("rm_drain");

        // Stuck-high ack before the push blocks the launch.
        ack_mode = M_HIGH;
        repeat (4) tick();
        push(2'b01, 1'b1);
        check("stuck_count", count, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stuck_send_low", send, 0);
        end
        ack_mode = M_AUTO;
        ack_dly  = 1;
        wait_send(1'b1, 10, "stuck_release");
        wait_drain("stuck_drain");

`ifdef TX_ACK_TIMEOUT_EN
        // Timeout in SEND: word kept, err set, word resent later.
        ack_mode = M_LOW;
        push(2'b10, 1'b1);
        tick();
        check("tmo_send_rise", send, 1);
        n = 0;
        while (send && n < 50) begin
            tick();
            n++;
        end
        check("tmo_send_cycles", n, TMO);
        check("tmo_err", err, 1);
        check("tmo_count", count, 1);
        exp_q.push_back(2'b10);
        ack_mode = M_AUTO;
        ack_dly  = 2;
        wait_send(1'b1, 10, "tmo_resend");
        wait_drain("tmo_drain");
        check("tmo_err_sticky", err, 1);
`else
        n = 0;
        check("err_tied_low", err, 0);
`endif

        check("all_words_delivered", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
